multicycle_seq: RTL and testbench

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/ack_watchdog.sv | 36 +++
 rtl/multicycle_seq.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: FSM states, control-word
// bit positions and the pc_sel / wb_sel selector values.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MUL_WAIT = 3'd3,
        ST_MEM      = 3'd4,
        ST_WB       = 3'd5,
        ST_FAULT    = 3'd6
    } state_e;

    localparam int CW_RS_MSB   = 31;
    localparam int CW_RS_LSB   = 27;
    localparam int CW_RT_MSB   = 26;
    localparam int CW_RT_LSB   = 22;
    localparam int CW_RD_MSB   = 21;
    localparam int CW_RD_LSB   = 17;
    localparam int CW_WR       = 16;
    localparam int CW_IMM      = 15;
    localparam int CW_ALU_MSB  = 14;
    localparam int CW_ALU_LSB  = 13;
    localparam int CW_MUL      = 12;
    localparam int CW_MUX2     = 11;
    localparam int CW_MEMWR    = 10;
    localparam int CW_WB2      = 9;
    localparam int CW_BR       = 8;
    localparam int CW_JMP      = 7;
    localparam int CW_RSVD_MSB = 6;

    localparam logic [1:0] PC_SEL_PC4 = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    localparam logic WB_SEL_MEM = 1'b0;
    localparam logic WB_SEL_ALU = 1'b1;

    // Only the fields the sequencer acts on after DECODE are kept.
    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic [1:0] alu;
        logic       mul;
        logic       memwr;
        logic       wb2;
        logic       br;
    } ctrl_t;

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive cycles a memory request waits without an ack and flags
// expiry in the cycle the count reaches MEM_TIMEOUT-1 while still waiting.
module ack_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic wait_active,
    output logic expired
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Any cycle without a pending request (including an ack cycle) clears the
    // count, so each new FETCH or MEM starts from zero.
    always_comb begin
        count_d = '0;
        expired = 1'b0;
        if (wait_active) begin
            count_d = count_q + CNT_W'(1);
            expired = (count_q == CNT_W'(MEM_TIMEOUT - 1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle MIPS-style control sequencer (FETCH/DECODE/EXEC/MUL_WAIT/MEM/WB/FAULT).
// Define MULTICYCLE_SEQ_TIMEOUT_EN to add the ack watchdog and the FAULT state.
module multicycle_seq
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ctrl_word,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        mul_done,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        mul_start,
    output logic        rf_we,
    output logic        fault,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_op,
    output logic [4:0]  rf_waddr,
    output logic        wb_sel,
    output logic [2:0]  state
);

    // Handshake: a req stays high until the cycle its ack is seen; an ack is
    // only meaningful while the matching req is high, and completes the
    // transfer in that same cycle (so an ack already high completes at once).

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    ctrl_t  ctrl_in;
    logic   timeout;
    logic   unused_ctrl_bits;

    assign ctrl_in.rd    = ctrl_word[CW_RD_MSB:CW_RD_LSB];
    assign ctrl_in.wr    = ctrl_word[CW_WR];
    assign ctrl_in.alu   = ctrl_word[CW_ALU_MSB:CW_ALU_LSB];
    assign ctrl_in.mul   = ctrl_word[CW_MUL];
    assign ctrl_in.memwr = ctrl_word[CW_MEMWR];
    assign ctrl_in.wb2   = ctrl_word[CW_WB2];
    assign ctrl_in.br    = ctrl_word[CW_BR];

    assign unused_ctrl_bits = ^{ctrl_word[CW_RS_MSB:CW_RS_LSB], ctrl_word[CW_RT_MSB:CW_RT_LSB],
                                ctrl_word[CW_IMM], ctrl_word[CW_MUX2], ctrl_word[CW_RSVD_MSB:0]};

`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    logic wait_active;

    assign wait_active = ((state_q == ST_FETCH) && !imem_ack) ||
                         ((state_q == ST_MEM) && !dmem_ack);

    ack_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_ack_watchdog (
        .clock       (clock),
        .reset       (reset),
        .wait_active (wait_active),
        .expired     (timeout)
    );
`else
    localparam int unused_mem_timeout = MEM_TIMEOUT;

    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        mul_start = 1'b0;
        rf_we     = 1'b0;
        fault     = 1'b0;
        pc_sel    = PC_SEL_PC4;
        alu_op    = 2'b00;
        rf_waddr  = 5'd0;
        wb_sel    = WB_SEL_MEM;
        state     = state_q;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_sel  = PC_SEL_PC4;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // The jump decision uses the live word: this is the latch cycle.
                ctrl_d = ctrl_in;
                if (ctrl_word[CW_JMP]) begin
                    pc_we   = 1'b1;
                    pc_sel  = PC_SEL_JMP;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op = ctrl_q.alu;
                if (ctrl_q.mul) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL_WAIT;
                end else if (ctrl_q.br) begin
                    pc_sel  = PC_SEL_BR;
                    pc_we   = br_taken;
                    state_d = ST_FETCH;
                end else if (ctrl_q.memwr || (ctrl_q.wr && !ctrl_q.wb2)) begin
                    state_d = ST_MEM;
                end else if (ctrl_q.wr) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctrl_q.memwr;
                if (dmem_ack) begin
                    state_d = ctrl_q.memwr ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = ctrl_q.rd;
                wb_sel   = ctrl_q.wb2 ? WB_SEL_ALU : WB_SEL_MEM;
                state_d  = ST_FETCH;
            end
            ST_FAULT: begin
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
                fault = 1'b1;
`endif
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (timeout) begin
            state_d = ST_FAULT;
        end

        // Reset silences every output combinationally, so a pending write or
        // request never completes in the reset cycle itself.
        if (reset) begin
            imem_req  = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            mul_start = 1'b0;
            rf_we     = 1'b0;
            fault     = 1'b0;
            pc_sel    = PC_SEL_PC4;
            alu_op    = 2'b00;
            rf_waddr  = 5'd0;
            wb_sel    = WB_SEL_MEM;
            state     = ST_FETCH;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: directed table, hand-written reset and
// wait sequences, and random instructions checked cycle by cycle.
module tb_multicycle_seq;

  localparam int MEM_TIMEOUT = 16;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       mul_start;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [4:0] rf_waddr;
    logic       wb_sel;
    logic       fault;
  } out_t;

  localparam int W = $bits(out_t);

  typedef struct packed {
    logic [31:0] cw;
    logic        ia;
    logic        da;
    logic        md;
    logic        bt;
  } in_t;

  typedef struct {
    string       name;
    logic [31:0] cw;
    int          iw;
    int          dw;
    int          mw;
    logic        bt;
    int          lat;
    int          n_wb;
    logic [4:0]  waddr;
    logic        wbs;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ctrl_word = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        mul_done = 1'b0;
  logic        br_taken = 1'b0;
  logic        imem_req, ir_we, pc_we, dmem_req, dmem_we, mul_start, rf_we, fault;
  logic [1:0]  pc_sel, alu_op;
  logic [4:0]  rf_waddr;
  logic        wb_sel;
  logic [2:0]  state;

  always #5 clock = ~clock;

  multicycle_seq #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ctrl_word (ctrl_word),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .mul_done  (mul_done),
    .br_taken  (br_taken),
    .imem_req  (imem_req),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .mul_start (mul_start),
    .rf_we     (rf_we),
    .fault     (fault),
    .pc_sel    (pc_sel),
    .alu_op    (alu_op),
    .rf_waddr  (rf_waddr),
    .wb_sel    (wb_sel),
    .state     (state)
  );

  out_t dut_o;
  assign dut_o = {state, imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, mul_start,
                  alu_op, rf_we, rf_waddr, wb_sel, fault};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  in_t          in_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  int           obs_lat;
  bit           obs_seen;
  bit           obs_done;
  int           obs_nwb;
  logic [4:0]   obs_waddr;
  logic         obs_wbs;

  function automatic string st_name(input logic [2:0] s);
    case (s)
      3'd0: return "fetch";
      3'd1: return "decode";
      3'd2: return "exec";
      3'd3: return "mul_wait";
      3'd4: return "mem";
      3'd5: return "wb";
      3'd6: return "fault";
      default: return "bad_state";
    endcase
  endfunction

  task automatic check(input string name, input out_t exp);
    n_cmp++;
    if (dut_o !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h (state %0d) want %h (state %0d) at %0t",
               name, dut_o, dut_o.state, exp, exp.state, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_obs();
    obs_lat = 0; obs_seen = 0; obs_done = 0; obs_nwb = 0; obs_waddr = '0; obs_wbs = 0;
  endtask

  task automatic observe();
    if (!obs_done) begin
      if (dut_o.state != 3'd0) obs_seen = 1;
      else if (obs_seen) obs_done = 1;
      if (!obs_done) obs_lat++;
    end
    if (dut_o.rf_we === 1'b1) begin
      obs_nwb++;
      obs_waddr = dut_o.rf_waddr;
      obs_wbs = dut_o.wb_sel;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic in_t noise();
    in_t i;
    i.cw = $urandom; i.ia = rbit(); i.da = rbit(); i.md = rbit(); i.bt = rbit();
    return i;
  endfunction

  function automatic logic [31:0] mk_cw(input int rs, input int rt, input int rd,
      input logic wr, input logic imm, input logic [1:0] alu, input logic mul,
      input logic memwr, input logic wb2, input logic br, input logic jmp);
    logic [4:0] a, b, c;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0];
    return {a, b, c, wr, imm, alu, mul, 1'b0, memwr, wb2, br, jmp, 7'd0};
  endfunction

  task automatic push(input in_t i, input out_t e);
    in_q.push_back(i);
    exp_q.push_back(e);
  endtask

  // Builds the expected per-cycle trace of one instruction directly from the
  // instruction class: fetch (iw stall cycles), decode, then the class path.
  task automatic gen(input logic [31:0] cw, input int iw, input int dw, input int mw,
                     input logic bt);
    in_t  i;
    out_t e;
    bit   to_wb;
    to_wb = 0;
    for (int k = 0; k <= iw; k++) begin
      i = noise(); i.ia = (k == iw);
      e = '0; e.imem_req = 1;
      if (k == iw) begin e.ir_we = 1; e.pc_we = 1; end
      push(i, e);
    end
    i = noise(); i.cw = cw;
    e = '0; e.state = 3'd1;
    if (cw[7]) begin
      e.pc_we = 1; e.pc_sel = 2'b10;
      push(i, e);
      return;
    end
    push(i, e);
    i = noise();
    e = '0; e.state = 3'd2; e.alu_op = cw[14:13];
    if (cw[12]) begin
      e.mul_start = 1;
      push(i, e);
      for (int k = 0; k <= mw; k++) begin
        i = noise(); i.md = (k == mw);
        e = '0; e.state = 3'd3;
        push(i, e);
      end
      to_wb = 1;
    end else if (cw[8]) begin
      i.bt = bt; e.pc_sel = 2'b01; e.pc_we = bt;
      push(i, e);
    end else if (cw[10] || (cw[16] && !cw[9])) begin
      push(i, e);
      for (int k = 0; k <= dw; k++) begin
        i = noise(); i.da = (k == dw);
        e = '0; e.state = 3'd4; e.dmem_req = 1; e.dmem_we = cw[10];
        push(i, e);
      end
      to_wb = !cw[10];
    end else begin
      push(i, e);
      to_wb = cw[16];
    end
    if (to_wb) begin
      i = noise();
      e = '0; e.state = 3'd5; e.rf_we = 1; e.rf_waddr = cw[21:17]; e.wb_sel = cw[9];
      push(i, e);
    end
  endtask

  task automatic step();
    in_t  i;
    out_t e;
    i = in_q.pop_front();
    e = exp_q.pop_front();
    @(negedge clock);
    reset = 0;
    ctrl_word = i.cw; imem_ack = i.ia; dmem_ack = i.da; mul_done = i.md; br_taken = i.bt;
    #1;
    check(st_name(e.state), e);
    observe();
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic flush();
    in_q.delete();
    exp_q.delete();
  endtask

  // Reset with every ack high: outputs must all read zero regardless.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      reset = 1;
      ctrl_word = $urandom; imem_ack = 1; dmem_ack = 1; mul_done = 1; br_taken = 1;
      #1;
      check("reset_outputs", '0);
      observe();
    end
  endtask

  task automatic run_vec(input vec_t v);
    clear_obs();
    gen(v.cw, v.iw, v.dw, v.mw, v.bt);
    run_steps(in_q.size());
    check_int({v.name, "_latency"}, obs_lat, v.lat);
    check_int({v.name, "_rf_we_cycles"}, obs_nwb, v.n_wb);
    if (v.n_wb > 0) begin
      check_int({v.name, "_rf_waddr"}, int'(obs_waddr), int'(v.waddr));
      check_int({v.name, "_wb_sel"}, int'(obs_wbs), int'(v.wbs));
    end
  endtask

  vec_t tbl[$];

  task automatic add(input string name, input logic [31:0] cw, input int iw, input int dw,
                     input int mw, input logic bt, input int lat, input int n_wb,
                     input int waddr, input logic wbs);
    vec_t v;
    v.name = name; v.cw = cw; v.iw = iw; v.dw = dw; v.mw = mw; v.bt = bt;
    v.lat = lat; v.n_wb = n_wb; v.waddr = waddr[4:0]; v.wbs = wbs;
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    //      name        cw: rs rt rd wr imm alu  mul mw wb2 br jmp       iw dw mw bt lat nwb wa wbs
    add("add_r7",  mk_cw(5, 6, 7, 1, 0, 2'b10, 0, 0, 1, 0, 0), 0, 0, 0, 0, 4, 1, 7, 1);
    add("lw_dly3", mk_cw(1, 0, 2, 1, 1, 2'b00, 0, 0, 0, 0, 0), 0, 3, 0, 0, 8, 1, 2, 0);
    add("sw_dly2", mk_cw(3, 4, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0), 0, 2, 0, 0, 6, 0, 0, 0);
    add("jmp",     mk_cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1), 0, 0, 0, 0, 2, 0, 0, 0);
    add("mul_r9",  mk_cw(2, 3, 9, 1, 0, 2'b11, 1, 0, 1, 0, 0), 0, 0, 0, 0, 5, 1, 9, 1);
    add("br_tkn",  mk_cw(1, 2, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0), 0, 0, 0, 1, 3, 0, 0, 0);
    add("br_not",  mk_cw(1, 2, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0), 0, 0, 0, 0, 3, 0, 0, 0);
    add("nop",     mk_cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), 0, 0, 0, 0, 3, 0, 0, 0);
    add("add_if2", mk_cw(5, 6, 31, 1, 0, 2'b00, 0, 0, 1, 0, 0), 2, 0, 0, 0, 6, 1, 31, 1);
    add("lw_z",    mk_cw(1, 0, 4, 1, 1, 2'b00, 0, 0, 0, 0, 0), 0, 0, 0, 0, 5, 1, 4, 0);
    add("sw_z",    mk_cw(3, 4, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0), 0, 0, 0, 0, 4, 0, 0, 0);
    add("mul_w3",  mk_cw(2, 3, 12, 1, 0, 2'b11, 1, 0, 1, 0, 0), 0, 0, 3, 0, 8, 1, 12, 1);
    add("mul_pri", mk_cw(2, 3, 3, 1, 0, 2'b01, 1, 1, 0, 1, 0), 0, 0, 0, 1, 5, 1, 3, 0);
    add("br_pri",  mk_cw(2, 3, 5, 1, 0, 2'b01, 0, 1, 0, 1, 0), 0, 0, 0, 1, 3, 0, 0, 0);
    add("st_wb2",  mk_cw(2, 3, 6, 1, 0, 2'b10, 0, 1, 1, 0, 0), 0, 1, 0, 0, 5, 0, 0, 0);

    do_reset(2);

    foreach (tbl[n]) run_vec(tbl[n]);

    // Reset during MEM of a load: the pending write never happens.
    clear_obs();
    gen(mk_cw(1, 0, 2, 1, 1, 2'b00, 0, 0, 0, 0, 0), 0, 5, 0, 0);
    run_steps(5);
    flush();
    do_reset(1);
    check_int("rst_mem_no_rf_we", obs_nwb, 0);
    run_vec(tbl[0]);

    // Reset landing exactly in the WB cycle of an ADD.
    clear_obs();
    gen(mk_cw(5, 6, 7, 1, 0, 2'b10, 0, 0, 1, 0, 0), 0, 0, 0, 0);
    run_steps(3);
    flush();
    do_reset(1);
    check_int("rst_wb_no_rf_we", obs_nwb, 0);

    // Reset during MUL_WAIT.
    clear_obs();
    gen(mk_cw(2, 3, 9, 1, 0, 2'b11, 1, 0, 1, 0, 0), 0, 0, 5, 0);
    run_steps(5);
    flush();
    do_reset(1);
    check_int("rst_mul_no_rf_we", obs_nwb, 0);
    run_vec(tbl[4]);

    // Random instructions against the trace model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] cw;
      cw = $urandom;
      if ($urandom_range(0, 7) != 0) cw[7] = 0;
      if ($urandom_range(0, 3) != 0) cw[12] = 0;
      if ($urandom_range(0, 3) != 0) cw[8] = 0;
      gen(cw, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
      run_steps(in_q.size());
    end

`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    begin
      out_t e;
      do_reset(1);
      for (int k = 0; k < MEM_TIMEOUT; k++) begin
        @(negedge clock);
        reset = 0; imem_ack = 0; dmem_ack = 1; mul_done = 1;
        #1;
        e = '0; e.imem_req = 1;
        check("timeout_wait", e);
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge clock);
        imem_ack = 1;
        #1;
        e = '0; e.state = 3'd6; e.fault = 1;
        check("timeout_fault", e);
      end
      do_reset(1);
    end
`else
    // Without the watchdog a long fetch stall is simply waited out.
    clear_obs();
    gen(mk_cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), 40, 0, 0, 0);
    run_steps(in_q.size());
    check_int("long_fetch_latency", obs_lat, 43);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
